// File: rtl/load_store_unit.sv
// Data-bus master: turns execute-stage load/store requests into a single-outstanding
// req/ready memory access, with lane steering, load extension and fault reporting.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;

  logic        access, legal, f3_ok, align_ok, timeout;
  logic [3:0]  be;
  logic [31:0] wd, ext;
  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    access = en & (dbus_re | dbus_we);
    if (dbus_re) f3_ok = (f3 == 3'b000) | (f3 == 3'b001) | (f3 == 3'b010) |
                         (f3 == 3'b100) | (f3 == 3'b101);
    else         f3_ok = (f3 == 3'b000) | (f3 == 3'b001) | (f3 == 3'b010);
    case (f3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    legal = ~(dbus_re & dbus_we) & f3_ok & align_ok;
  end

  // Store lane steering; loads always fetch the whole word.
  always_comb begin
    case (f3[1:0])
      2'b00: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{store_data[7:0]}};
      end
      2'b01: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{store_data[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = store_data;
      end
    endcase
    if (dbus_re) be = 4'b1111;
  end

  always_comb begin
    case (off_q)
      2'd0:    lb = mem_rdata[7:0];
      2'd1:    lb = mem_rdata[15:8];
      2'd2:    lb = mem_rdata[23:16];
      default: lb = mem_rdata[31:24];
    endcase
    lh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{lb[7]}}, lb};
      3'b001:  ext = {{16{lh[15]}}, lh};
      3'b100:  ext = {24'd0, lb};
      3'b101:  ext = {16'd0, lh};
      default: ext = mem_rdata;
    endcase
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign mem_req = (state == S_WAIT);
  // Gated by rst so a held request cannot keep stall high while in reset.
  assign stall   = mem_req | (rst & (state == S_IDLE) & access & legal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      fault      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (legal) begin
              state     <= S_WAIT;
              f3_q      <= f3;
              off_q     <= addr[1:0];
              cnt       <= '0;
              mem_we    <= dbus_we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wd;
            end else begin
              state <= S_DONE;
              fault <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // A ready arriving on the last allowed cycle still completes normally.
          if (mem_ready) begin
            state <= S_DONE;
            if (!mem_we) begin
              load_valid <= 1'b1;
              load_data  <= ext;
            end
          end else if (timeout) begin
            state <= S_DONE;
            fault <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
